// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg
//   Shared definitions for the register-file arbiter slice: register-file
//   geometry, the arbitration state encoding and the decoded command record
//   that the issue stage muxes out of the winning requester's slices.
`timescale 1ns/1ps
package regfile_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_DATA_W-1:0] wdata;
    logic [REG_ADDR_W-1:0] raddr_a;
    logic [REG_ADDR_W-1:0] raddr_b;
  } rf_cmd_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int req_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if
//   Requester-side bundle of the register-file arbiter.
//   master : requesters (drive commands, receive ready and read responses)
//   slave  : the arbiter
//   req_valid/req_ready  per-requester command handshake
//   req_rd/req_wr        command performs a two-register read and/or a write
//   req_waddr/req_wdata  write index/data, slice i belongs to requester i
//   req_raddr_a/_b       read indices, slice i belongs to requester i
//   req_lock             keep the grant after this command (lock build only)
//   rsp_valid/rsp_id     one-cycle read response pulse and its owner
//   rsp_data_a/_b        read data
`timescale 1ns/1ps
interface regfile_arbiter_if #(
  parameter int N_REQ = 2
);
  import regfile_arb_pkg::*;

  localparam int REQ_W = req_w(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            req_rd;
  logic [N_REQ-1:0]            req_wr;
  logic [REG_ADDR_W*N_REQ-1:0] req_waddr;
  logic [REG_DATA_W*N_REQ-1:0] req_wdata;
  logic [REG_ADDR_W*N_REQ-1:0] req_raddr_a;
  logic [REG_ADDR_W*N_REQ-1:0] req_raddr_b;
  logic [N_REQ-1:0]            req_lock;
  logic                        rsp_valid;
  logic [REQ_W-1:0]            rsp_id;
  logic [REG_DATA_W-1:0]       rsp_data_a;
  logic [REG_DATA_W-1:0]       rsp_data_b;

  modport master (
    output req_valid, req_rd, req_wr, req_waddr, req_wdata,
           req_raddr_a, req_raddr_b, req_lock,
    input  req_ready, rsp_valid, rsp_id, rsp_data_a, rsp_data_b
  );

  modport slave (
    input  req_valid, req_rd, req_wr, req_waddr, req_wdata,
           req_raddr_a, req_raddr_b, req_lock,
    output req_ready, rsp_valid, rsp_id, rsp_data_a, rsp_data_b
  );

endinterface

// File: rtl/regfile_arbiter_rr_picker.sv
// rr_picker
//   Round-robin priority picker. The first set bit of valid, searching from
//   rr_ptr upward and wrapping modulo N_REQ, wins.
//   valid   in   request vector
//   rr_ptr  in   highest-priority index this cycle
//   grant   out  one-hot winner (zero when nothing is valid)
//   idx     out  binary winner index (zero when nothing is valid)
//   any     out  at least one request is valid
`timescale 1ns/1ps
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int REQ_W = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [REQ_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [REQ_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    // Walk distances from the farthest to the nearest so the requester
    // closest to rr_ptr overwrites any earlier candidate.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      for (int m = 0; m < N_REQ; m++) begin
        if (valid[m] && (m == ((int'(rr_ptr) + k) % N_REQ))) begin
          idx = REQ_W'(m);
        end
      end
    end
    any   = |valid;
    grant = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Shares one 32x32 register file (1 write, 2 read ports, synchronous) among
//   N_REQ requesters. One command is granted per cycle with round-robin
//   fairness; the grant and the register-file strobes/selects are
//   combinational from the requests, and read data is returned one cycle
//   after the accept edge, tagged with the owning requester.
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   bus (slave)         requester command handshake and read responses
//   rf_en/rf_read/rf_write, rf_sel_w/_r1/_r2, rf_wdata   register-file controls
//   rf_out_a/rf_out_b   register-file read outputs
//   Build option: define REGFILE_ARB_LOCK_EN to let a requester hold the
//   grant across several commands (atomic read-modify-write). Without it
//   req_lock is ignored and arbitration is pure round-robin.
`timescale 1ns/1ps
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int REQ_W = req_w(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_arbiter_if.slave      bus,
  output logic                  rf_en,
  output logic                  rf_read,
  output logic                  rf_write,
  output logic [REG_ADDR_W-1:0] rf_sel_w,
  output logic [REG_ADDR_W-1:0] rf_sel_r1,
  output logic [REG_ADDR_W-1:0] rf_sel_r2,
  output logic [REG_DATA_W-1:0] rf_wdata,
  input  logic [REG_DATA_W-1:0] rf_out_a,
  input  logic [REG_DATA_W-1:0] rf_out_b
);

  logic [REQ_W-1:0] rr_ptr;
  logic [N_REQ-1:0] mask_p0;
  logic [N_REQ-1:0] vld_p0;
  logic [N_REQ-1:0] grant_p0;
  logic [REQ_W-1:0] idx_p0;
  logic             any_p0;
  logic             ptr_frozen;
  rf_cmd_t          cmd_p0;
  logic             rd_pending;
  logic [REQ_W-1:0] rsp_id_p1;

  function automatic logic [REQ_W-1:0] next_ptr(input logic [REQ_W-1:0] cur);
    return (cur == REQ_W'(N_REQ - 1)) ? '0 : cur + 1'b1;
  endfunction

`ifdef REGFILE_ARB_LOCK_EN
  arb_state_t       state_q, state_d;
  logic [REQ_W-1:0] owner_q, owner_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OPEN;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (any_p0) begin
      case (state_q)
        OPEN: begin
          if (bus.req_lock[idx_p0]) begin
            state_d = LOCKED;
            owner_d = idx_p0;
          end
        end
        LOCKED: begin
          // Only the owner can be granted here, so this is its unlock.
          if (!bus.req_lock[idx_p0]) begin
            state_d = OPEN;
          end
        end
        default: state_d = OPEN;
      endcase
    end
  end

  assign mask_p0    = (state_q == LOCKED) ? (N_REQ'(1) << owner_q) : '1;
  assign ptr_frozen = (state_q == LOCKED);
`else
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
  assign mask_p0     = '1;
  assign ptr_frozen  = 1'b0;
`endif

  // ---- p0: issue stage (combinational grant and register-file drive) ----
  // Grants are suppressed while reset is held so every output reads zero.
  assign vld_p0 = rst ? '0 : (bus.req_valid & mask_p0);

  rr_picker #(
    .N_REQ (N_REQ),
    .REQ_W (REQ_W)
  ) u_picker (
    .valid  (vld_p0),
    .rr_ptr (rr_ptr),
    .grant  (grant_p0),
    .idx    (idx_p0),
    .any    (any_p0)
  );

  always_comb begin
    cmd_p0.rd      = bus.req_rd[idx_p0];
    cmd_p0.wr      = bus.req_wr[idx_p0];
    cmd_p0.waddr   = bus.req_waddr[int'(idx_p0)*REG_ADDR_W +: REG_ADDR_W];
    cmd_p0.wdata   = bus.req_wdata[int'(idx_p0)*REG_DATA_W +: REG_DATA_W];
    cmd_p0.raddr_a = bus.req_raddr_a[int'(idx_p0)*REG_ADDR_W +: REG_ADDR_W];
    cmd_p0.raddr_b = bus.req_raddr_b[int'(idx_p0)*REG_ADDR_W +: REG_ADDR_W];
  end

  // A granted command with neither rd nor wr is consumed without touching
  // the register file.
  always_comb begin
    rf_en     = 1'b0;
    rf_read   = 1'b0;
    rf_write  = 1'b0;
    rf_sel_w  = '0;
    rf_sel_r1 = '0;
    rf_sel_r2 = '0;
    rf_wdata  = '0;
    if (any_p0 && (cmd_p0.rd || cmd_p0.wr)) begin
      rf_en     = 1'b1;
      rf_read   = cmd_p0.rd;
      rf_write  = cmd_p0.wr;
      rf_sel_w  = cmd_p0.waddr;
      rf_sel_r1 = cmd_p0.raddr_a;
      rf_sel_r2 = cmd_p0.raddr_b;
      rf_wdata  = cmd_p0.wdata;
    end
  end

  assign bus.req_ready = grant_p0;

  // ---- p1: response stage (data arrives from the register file) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      rd_pending <= 1'b0;
      rsp_id_p1  <= '0;
    end else begin
      rd_pending <= any_p0 && cmd_p0.rd;
      if (any_p0 && cmd_p0.rd) begin
        rsp_id_p1 <= idx_p0;
      end
      if (any_p0 && !ptr_frozen) begin
        rr_ptr <= next_ptr(idx_p0);
      end
    end
  end

  assign bus.rsp_valid  = rd_pending;
  assign bus.rsp_id     = rsp_id_p1;
  assign bus.rsp_data_a = rd_pending ? rf_out_a : '0;
  assign bus.rsp_data_b = rd_pending ? rf_out_b : '0;

endmodule
